uart_prog_loader: RTL and testbench

Program-loader controller that sits between `uart_rx` and the CPU program memory. It parses framed bytes delivered by the receiver's valid strobe, writes the payload into memory at a host-given start address, and holds the CPU in halt while a load is in progress. It reports frame completion, checksum and timeout errors as single-cycle strobes.

---
 rtl/uart_prog_loader.sv | 213 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// ----------------------------------------------------------------------------
// uart_prog_loader
//
// Program-loader controller placed between uart_rx and the CPU program memory.
// It parses framed bytes (SYNC, ADDR, COUNT, COUNT data bytes[, CHK]), writes
// the payload into program memory starting at ADDR, and keeps the CPU halted
// while a load is in progress. Completion and error are reported as
// single-cycle strobes.
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, a trailing CHK byte is expected and is
//                       compared against the running XOR of ADDR, COUNT and
//                       all data bytes; a mismatch raises the error strobe.
//                       When undefined, the frame ends after the last data
//                       byte (or after COUNT = 0) and errors come only from
//                       the inter-byte timeout.
//
// Ports:
//   clk_i              system clock
//   reset_i            asynchronous active-low reset
//   rx_data_i          received byte from uart_rx
//   rx_valid_strb_i    one-cycle strobe qualifying rx_data_i
//   mem_we_o           one-cycle program-memory write enable
//   mem_addr_o         write address (held between writes)
//   mem_data_o         write data (held between writes)
//   cpu_halt_o         CPU halt request
//   busy_o             high while the loader is not idle
//   load_done_strb_o   one-cycle strobe on a successful frame
//   load_error_strb_o  one-cycle strobe on checksum error or timeout
// ----------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int unsigned           DATA_WIDTH       = 8,
    parameter int unsigned           ADDR_WIDTH       = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE        = 8'hA5,
    parameter int unsigned           TIMEOUT_CYCLES   = 52100,
    parameter int unsigned           TIMEOUT_BITWIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_strb_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_halt_o,
    output logic                  busy_o,
    output logic                  load_done_strb_o,
    output logic                  load_error_strb_o
);

    localparam logic [TIMEOUT_BITWIDTH-1:0] TmoLast = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_BITWIDTH-1:0] TmoOne  = TIMEOUT_BITWIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]       AddrOne = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]       CntOne  = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCount,
        StData,
`ifdef LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDone,
        StErr
    } state_e;

    state_e                       state_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]        cnt_q;
    logic [TIMEOUT_BITWIDTH-1:0]  tmo_q;
    logic                         mem_we_q;
    logic [ADDR_WIDTH-1:0]        mem_addr_q;
    logic [DATA_WIDTH-1:0]        mem_data_q;
    logic                         halt_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]        xor_q;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            // Strobes default low so each is exactly one cycle wide.
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    tmo_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_q <= '0;
`endif
                    if (rx_valid_strb_i && (rx_data_i == SYNC_BYTE)) begin
                        state_q <= StAddr;
                        busy_q  <= 1'b1;
                    end
                end

                StDone: begin
                    done_q  <= 1'b1;
                    halt_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                // Halt is deliberately left set: memory may be partially written.
                StErr: begin
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                // In-frame states share the timeout; a strobe beats expiry.
                default: begin
                    if (rx_valid_strb_i) begin
                        tmo_q <= '0;
                        unique case (state_q)
                            StAddr: begin
                                addr_q  <= ADDR_WIDTH'(rx_data_i);
                                halt_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                                xor_q   <= xor_q ^ rx_data_i;
`endif
                                state_q <= StCount;
                            end

                            StCount: begin
                                cnt_q <= rx_data_i;
`ifdef LOADER_CHECKSUM_EN
                                xor_q <= xor_q ^ rx_data_i;
`endif
                                if (rx_data_i != '0) begin
                                    state_q <= StData;
                                end else begin
`ifdef LOADER_CHECKSUM_EN
                                    state_q <= StCheck;
`else
                                    state_q <= StDone;
`endif
                                end
                            end

                            StData: begin
                                mem_we_q   <= 1'b1;
                                mem_addr_q <= addr_q;
                                mem_data_q <= rx_data_i;
                                addr_q     <= addr_q + AddrOne;  // wraps modulo 2^ADDR_WIDTH
                                cnt_q      <= cnt_q - CntOne;
`ifdef LOADER_CHECKSUM_EN
                                xor_q      <= xor_q ^ rx_data_i;
`endif
                                if (cnt_q == CntOne) begin
`ifdef LOADER_CHECKSUM_EN
                                    state_q <= StCheck;
`else
                                    state_q <= StDone;
`endif
                                end
                            end

`ifdef LOADER_CHECKSUM_EN
                            StCheck: begin
                                if (rx_data_i == xor_q) begin
                                    state_q <= StDone;
                                end else begin
                                    state_q <= StErr;
                                end
                            end
`endif

                            default: begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end else if (tmo_q == TmoLast) begin
                        tmo_q   <= '0;
                        state_q <= StErr;
                    end else begin
                        tmo_q <= tmo_q + TmoOne;
                    end
                end
            endcase
        end
    end

    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_data_o        = mem_data_q;
    assign cpu_halt_o        = halt_q;
    assign busy_o            = busy_q;
    assign load_done_strb_o  = done_q;
    assign load_error_strb_o = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader. Bytes are presented as one-cycle
// strobes (back-to-back inside frames); write, halt, busy and strobe timing
// are checked against hand-derived expectations. Works with or without
// LOADER_CHECKSUM_EN defined.
// ----------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int unsigned Tmo = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strb = 1'b0;

    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_halt;
    logic       busy;
    logic       done_strb;
    logic       err_strb;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int exp_wr   = 0;
    int exp_done = 0;
    int exp_err  = 0;

    logic [7:0] q[$];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_n),
        .rx_data_i        (rx_data),
        .rx_valid_strb_i  (rx_strb),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_data_o       (mem_data),
        .cpu_halt_o       (cpu_halt),
        .busy_o           (busy),
        .load_done_strb_o (done_strb),
        .load_error_strb_o(err_strb)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we)    wr_count++;
        if (done_strb) done_cnt++;
        if (err_strb)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_strb = 1'b1;
        @(negedge clk);
        rx_strb = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] a, input logic [7:0] d, input string tag);
        send(d);
        check({tag, "_we"},   {31'd0, mem_we}, 32'd1);
        check({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, a});
        check({tag, "_data"}, {24'd0, mem_data}, {24'd0, d});
        exp_wr++;
    endtask

    // Entered one half-cycle after the frame's final strobe was captured.
    task automatic expect_end(input bit ok, input logic halt_exp, input string tag);
        check({tag, "_pre"}, {29'd0, done_strb, err_strb, busy}, 32'b001);
        @(negedge clk);
        if (ok) begin
            check({tag, "_done"}, {28'd0, done_strb, err_strb, busy, cpu_halt}, 32'b1000);
            exp_done++;
        end else begin
            check({tag, "_err"}, {28'd0, done_strb, err_strb, busy, cpu_halt},
                  {28'd0, 3'b010, halt_exp});
            exp_err++;
        end
        @(negedge clk);
        check({tag, "_idle"}, {29'd0, done_strb, err_strb, busy}, 32'b000);
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] data[$],
                              input logic [7:0] chk_flip, input bit ok,
                              input logic halt_exp, input string tag);
        logic [7:0] x;
        logic [7:0] a;
        x = addr ^ 8'(data.size()) ^ chk_flip;
        a = addr;
        send(8'hA5);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        send(addr);
        check({tag, "_halt"}, {31'd0, cpu_halt}, 32'd1);
        send(8'(data.size()));
        foreach (data[i]) begin
            send_data(a, data[i], tag);
            x = x ^ data[i];
            a = a + 8'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        send(x);
`endif
        expect_end(ok, halt_exp, tag);
    endtask

    // Entered one half-cycle after the strobe that entered an in-frame state.
    task automatic wait_timeout(input logic halt_exp, input string tag);
        repeat (Tmo) @(negedge clk);
        check({tag, "_pre"}, {30'd0, err_strb, busy}, 32'b01);
        @(negedge clk);
        check({tag, "_err"}, {29'd0, err_strb, busy, cpu_halt}, {29'd0, 2'b10, halt_exp});
        exp_err++;
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, err_strb, busy}, 32'b00);
    endtask

    initial begin
        #(200_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;

        #1;
        check("reset_outs", {13'd0, mem_we, mem_addr, mem_data, cpu_halt, busy, done_strb, err_strb},
              32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Non-sync byte in idle is ignored.
        send(8'h33);
        @(negedge clk);
        check("idle_ignore", {30'd0, busy, cpu_halt}, 32'd0);

        q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h10, q, 8'h00, 1'b1, 1'b0, "basic");
        check("hold_addr", {24'd0, mem_addr}, 32'h12);
        check("hold_data", {24'd0, mem_data}, 32'h33);

`ifdef LOADER_CHECKSUM_EN
        send_frame(8'h10, q, 8'h01, 1'b0, 1'b1, "badchk");
        check("badchk_halt_stays", {31'd0, cpu_halt}, 32'd1);
        q = {8'h01};
        send_frame(8'h70, q, 8'h00, 1'b1, 1'b0, "release");
`endif

        q = {8'hAA, 8'hBB, 8'hCC};
        send_frame(8'hFE, q, 8'h00, 1'b1, 1'b0, "wrap");

        // SYNC value inside the payload is plain data.
        q = {8'hA5, 8'hA5};
        send_frame(8'h60, q, 8'h00, 1'b1, 1'b0, "sync_data");

        wr_before = wr_count;
        q.delete();
        send_frame(8'h40, q, 8'h00, 1'b1, 1'b0, "zero_cnt");
        check("zero_cnt_nowr", wr_count - wr_before, 32'd0);

        // Timeout while waiting for ADDR: halt never raised.
        send(8'hA5);
        wait_timeout(1'b0, "tmo_addr");
        send(8'h55);
        @(negedge clk);
        check("tmo_addr_ignore", {30'd0, busy, cpu_halt}, 32'd0);

        // Timeout while waiting for COUNT: halt stays up afterwards.
        send(8'hA5);
        send(8'h20);
        wait_timeout(1'b1, "tmo_cnt");
        wr_before = wr_count;
        send(8'h55);
        @(negedge clk);
        check("tmo_cnt_ignore", {30'd0, busy, cpu_halt}, 32'b01);
        check("tmo_cnt_nowr", wr_count - wr_before, 32'd0);
        q = {8'h5A};
        send_frame(8'h80, q, 8'h00, 1'b1, 1'b0, "tmo_release");

        // Strobe arriving in the expiry cycle wins.
        send(8'hA5);
        repeat (Tmo - 1) @(negedge clk);
        send(8'h30);
        check("edge_accept", {29'd0, cpu_halt, busy, err_strb}, 32'b110);
        send(8'h01);
        send_data(8'h30, 8'h77, "edge");
`ifdef LOADER_CHECKSUM_EN
        send(8'h30 ^ 8'h01 ^ 8'h77);
`endif
        expect_end(1'b1, 1'b0, "edge");

        // Reset mid-frame.
        send(8'hA5);
        send(8'h50);
        send(8'h04);
        send_data(8'h50, 8'h01, "rst_pre");
        send_data(8'h51, 8'h02, "rst_pre");
        reset_n = 1'b0;
        #1;
        check("rst_async", {13'd0, mem_we, mem_addr, mem_data, cpu_halt, busy, done_strb, err_strb},
              32'd0);
        @(negedge clk);
        check("rst_hold", {28'd0, mem_we, cpu_halt, busy, done_strb}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        q = {8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'h50, q, 8'h00, 1'b1, 1'b0, "rst_reload");

        repeat (3) @(negedge clk);
        check("total_writes", wr_count, exp_wr);
        check("total_done", done_cnt, exp_done);
        check("total_err", err_cnt, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
